// File: rtl/lau_pkg.sv
// Shared types for the carry-save accumulator: FSM state encoding and
// compressor speed selection.
package lau_pkg;

    // Accumulator controller states.
    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } csv_acc_state_e;

    // Compressor implementation choice: FAST keeps the result in carry-save
    // form, SLOW collapses it with a carry-propagate adder.
    typedef enum logic {
        FAST = 1'b0,
        SLOW = 1'b1
    } speed_e;

endpackage

// File: rtl/csv_acc_uns_add_mop_csv.sv
// Multi-operand compressor: reduces nOps unsigned words to a sum/carry pair
// whose arithmetic sum equals the operand sum modulo 2^width.
module AddMopCsv
    import lau_pkg::*;
#(
    parameter int     width = 20,
    parameter int     nOps  = 4,
    parameter speed_e speed = FAST
) (
    input  logic [nOps-1:0][width-1:0] ops,
    output logic [width-1:0]           sum,
    output logic [width-1:0]           carry
);

    if (nOps < 2 || width < 2) begin : g_bad_params
        $error("AddMopCsv needs at least two operands of at least two bits");
    end

    if (speed == FAST) begin : g_csa
        // Chain of 3:2 counters; each stage folds one more operand into the
        // running sum/carry pair without propagating carries.
        always_comb begin
            logic [width-1:0] s;
            logic [width-1:0] c;
            logic [width-1:0] maj;
            // NOTE: blocking assignments are correct here because this is
            // combinational; every variable gets a value before any branch so
            // no latch can be inferred.
            s   = ops[0];
            c   = ops[1];
            maj = '0;
            for (int i = 2; i < nOps; i++) begin
                maj = (s & c) | (s & ops[i]) | (c & ops[i]);
                s   = s ^ c ^ ops[i];
                c   = {maj[width-2:0], 1'b0};
            end
            sum   = s;
            carry = c;
        end
    end else begin : g_cpa
        // Plain carry-propagate sum; carry word is always zero.
        always_comb begin
            logic [width-1:0] s;
            s = '0;
            for (int i = 0; i < nOps; i++) begin
                s = s + ops[i];
            end
            sum   = s;
            carry = '0;
        end
    end

endmodule

// File: rtl/csv_acc_uns.sv
// Unsigned carry-save accumulator: folds carry-save products into a redundant
// accumulator one per cycle, then resolves it to binary chunk by chunk.
module csv_acc_uns
    import lau_pkg::*;
#(
    parameter int     widthIn = 16,
    parameter int     guard   = 4,
    parameter int     chunk   = 5,
    parameter speed_e speed   = FAST
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [widthIn-1:0]         PS,
    input  logic [widthIn-1:0]         PC,
    input  logic                       Last,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [widthIn+guard-1:0]   Z,
    output logic                       Ovf
);

    localparam int accWidth = widthIn + guard;
    localparam int N        = accWidth / chunk;
    localparam int IdxW     = (N > 1) ? $clog2(N) : 1;

    localparam logic [IdxW-1:0] idx_last  = IdxW'(N - 1);
    localparam logic [guard:0]  cnt_max   = '1;
    localparam logic [guard:0]  cnt_limit = {1'b1, {guard{1'b0}}};

    if (accWidth % chunk != 0) begin : g_bad_chunk
        $error("accumulator width must be a multiple of chunk");
    end

    csv_acc_state_e state, state_nxt;

    logic [accWidth-1:0]         acc_s, acc_c;
    logic [accWidth-1:0]         comp_s, comp_c;
    logic [3:0][accWidth-1:0]    ops;
    logic [guard:0]              cnt, cnt_inc;
    logic [IdxW-1:0]             idx;
    logic                        carry;
    logic [chunk:0]              chunk_sum;
    int                          base;
    logic                        in_fire, out_fire;

    assign in_ready_o  = (state == ACC) && !clr_i;
    assign out_valid_o = (state == OUT);
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    assign ops = {acc_s, acc_c, {{guard{1'b0}}, PS}, {{guard{1'b0}}, PC}};

    AddMopCsv #(
        .width (accWidth),
        .nOps  (4),
        .speed (speed)
    ) u_comp (
        .ops   (ops),
        .sum   (comp_s),
        .carry (comp_c)
    );

    assign cnt_inc   = (cnt == cnt_max) ? cnt : cnt + 1'b1;
    assign base      = int'(idx) * chunk;
    assign chunk_sum = {1'b0, acc_s[base +: chunk]} + {1'b0, acc_c[base +: chunk]}
                     + (chunk + 1)'(carry);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) state <= ACC;
        else         state <= state_nxt;
    end

    // Next-state logic: accept until Last, resolve N chunks, wait for consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (in_fire && Last)   state_nxt = RESOLVE;
            RESOLVE: if (idx == idx_last)   state_nxt = OUT;
            OUT:     if (out_ready_i)       state_nxt = ACC;
            default:                        state_nxt = ACC;
        endcase
    end

    // Accumulator, operand counter, chunk resolver and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_s <= '0;
            acc_c <= '0;
            cnt   <= '0;
            Ovf   <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            Z     <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (clr_i) begin
                        acc_s <= '0;
                        acc_c <= '0;
                        cnt   <= '0;
                        Ovf   <= 1'b0;
                    end else if (in_valid_i) begin
                        acc_s <= comp_s;
                        acc_c <= comp_c;
                        cnt   <= cnt_inc;
                        if (cnt_inc > cnt_limit) Ovf <= 1'b1;
                        if (Last) begin
                            idx   <= '0;
                            carry <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    Z[base +: chunk] <= chunk_sum[chunk-1:0];
                    carry            <= chunk_sum[chunk];
                    idx              <= (idx == idx_last) ? '0 : idx + 1'b1;
                end
                OUT: begin
                    if (out_fire) begin
                        acc_s <= '0;
                        acc_c <= '0;
                        cnt   <= '0;
                        Ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csv_acc_uns.sv
// Directed bench for csv_acc_uns with widthIn=16, guard=4, chunk=5 (N=4).
module tb_csv_acc_uns;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clr_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] PS = '0;
    logic [15:0] PC = '0;
    logic        Last = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [19:0] Z;
    logic        Ovf;

    int tests = 0;
    int fails = 0;

    csv_acc_uns #(
        .widthIn (16),
        .guard   (4),
        .chunk   (5)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .PS          (PS),
        .PC          (PC),
        .Last        (Last),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .Z           (Z),
        .Ovf         (Ovf)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one operand for a single accepting edge.
    task automatic send(input logic [15:0] ps, input logic [15:0] pc, input logic last);
        PS = ps; PC = pc; Last = last; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0; Last = 1'b0; PS = '0; PC = '0;
    endtask

    // Count edges from the Last handshake until out_valid_o, bounded.
    task automatic wait_out(input string tag);
        int cycles = 0;
        while (!out_valid_o && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, 4);
    endtask

    task automatic take(input string tag, input logic [19:0] z_exp, input logic ovf_exp);
        check({tag, "_z"}, {12'd0, Z}, {12'd0, z_exp});
        check({tag, "_ovf"}, {31'd0, Ovf}, {31'd0, ovf_exp});
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({tag, "_back_to_acc"}, {31'd0, in_ready_o}, 32'd1);
    endtask

    initial begin
        // Reset values.
        #12;
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_z", {12'd0, Z}, 32'd0);
        check("rst_ovf", {31'd0, Ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single operand: 0xFF + 0x01 = 0x100.
        send(16'h00FF, 16'h0001, 1'b1);
        check("single_busy", {31'd0, in_ready_o}, 32'd0);
        wait_out("single");
        take("single", 20'h00100, 1'b0);

        // Carry ripples through several chunks: 2 * 0x10000.
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b1);
        wait_out("chain");
        take("chain", 20'h20000, 1'b0);

        // 16 operands: exactly at the counter limit, no overflow.
        for (int i = 0; i < 16; i++) send(16'hFFFF, 16'h0000, i == 15);
        wait_out("ovf16");
        take("ovf16", 20'hFFFF0, 1'b0);

        // 17 operands: 17*0xFFFF = 0x10FFEF wraps to 0x0FFEF, overflow flagged.
        for (int i = 0; i < 17; i++) send(16'hFFFF, 16'h0000, i == 16);
        wait_out("ovf17");
        take("ovf17", 20'h0FFEF, 1'b1);

        // Backpressure, with clear and junk operands driven while in OUT.
        send(16'h1234, 16'h0101, 1'b1);
        wait_out("bp");
        clr_i = 1'b1; in_valid_i = 1'b1; PS = 16'hAAAA; PC = 16'h5555; Last = 1'b1;
        begin
            logic ok = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (!(out_valid_o && Z == 20'h01335 && !in_ready_o && !Ovf)) ok = 1'b0;
            end
            check("bp_hold", {31'd0, ok}, 32'd1);
        end
        clr_i = 1'b0; in_valid_i = 1'b0; PS = '0; PC = '0; Last = 1'b0;
        take("bp", 20'h01335, 1'b0);
        send(16'h0003, 16'h0000, 1'b1);
        wait_out("bp_next");
        take("bp_next", 20'h00003, 1'b0);

        // Clear beats a simultaneous valid operand.
        send(16'h0010, 16'h0000, 1'b0);
        clr_i = 1'b1; in_valid_i = 1'b1; PS = 16'h0005; PC = '0; Last = 1'b1;
        #1;
        check("clr_in_ready", {31'd0, in_ready_o}, 32'd0);
        tick();
        clr_i = 1'b0; in_valid_i = 1'b0; PS = '0; Last = 1'b0;
        tick();
        check("clr_no_resolve", {31'd0, out_valid_o}, 32'd0);
        check("clr_ready_again", {31'd0, in_ready_o}, 32'd1);
        send(16'h0001, 16'h0000, 1'b1);
        wait_out("clr");
        take("clr", 20'h00001, 1'b0);

        // Reset during the second resolve cycle.
        send(16'h0010, 16'h0000, 1'b0);
        send(16'h00FF, 16'h0001, 1'b1);
        tick();
        rst_ni = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("midrst_z", {12'd0, Z}, 32'd0);
        check("midrst_ovf", {31'd0, Ovf}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("postrst_idle", {31'd0, out_valid_o}, 32'd0);
        check("postrst_ready", {31'd0, in_ready_o}, 32'd1);
        send(16'h0002, 16'h0000, 1'b1);
        wait_out("postrst");
        take("postrst", 20'h00002, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csv_acc_uns.md
CSV_ACC_UNS -- requirements
Module: CsvAccUns

Interface
REQ-001 SHALL have parameter widthIn, default 16, word width of carry-save inputs PS/PC.
REQ-002 SHALL have parameter guard, default 4, guard bits; accWidth = widthIn+guard.
REQ-003 SHALL have parameter chunk, default 5, bits resolved per cycle; accWidth mod chunk = 0 (elaboration error otherwise); N = accWidth/chunk.
REQ-004 SHALL have parameter speed, default lau_pkg::FAST, speed of the compressor tree.
REQ-005 SHALL have port clk_i  in  1  clock, rising edge.
REQ-006 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-007 SHALL have port clr_i  in  1  synchronous accumulator clear.
REQ-008 SHALL have port in_valid_i  in  1  PS/PC/Last valid.
REQ-009 SHALL have port in_ready_o  out  1  operand accepted.
REQ-010 SHALL have ports PS and PC  in  widthIn  carry-save product (sum, carry), as produced by an unsigned carry-save multiplier.
REQ-011 SHALL have port Last  in  1  final operand of the accumulation.
REQ-012 SHALL have port out_valid_o  out  1  result valid.
REQ-013 SHALL have port out_ready_i  in  1  result consumed.
REQ-014 SHALL have port Z  out  accWidth  binary accumulated sum.
REQ-015 SHALL have port Ovf  out  1  operand-count overflow flag.

Function
REQ-016 SHALL implement FSM states ACC, RESOLVE, OUT; reset state is ACC.
REQ-017 SHALL drive in_ready_o = (state==ACC) && !clr_i; out_valid_o = (state==OUT).
REQ-018 SHALL, on the ACC input handshake, update AccS/AccC <= 4:2 compression of {AccS, AccC, zext(PS), zext(PC)}, modulo 2^accWidth, in a single cycle.
REQ-019 SHALL count accepted operands in a (guard+1)-bit saturating counter; Ovf is set sticky when the count exceeds 2^guard.
REQ-020 SHALL, on a handshake with Last=1, accept that operand and then enter RESOLVE with chunk index 0 and carry register 0.
REQ-021 SHALL, in RESOLVE, add chunk k of AccS+AccC+carry each cycle, store it into Z[k*chunk +: chunk], and register carry-out; chunk N-1 carry-out is discarded.
REQ-022 SHALL enter OUT on the edge that resolves chunk N-1; out_valid_o therefore rises N cycles after the Last handshake edge.
REQ-023 SHALL hold Z and Ovf stable while out_valid_o=1 and out_ready_i=0.
REQ-024 SHALL, on the output handshake, clear AccS, AccC, the counter, and Ovf, and return to ACC; Z holds its value until the next RESOLVE.
REQ-025 SHALL, with clr_i=1 in ACC, clear AccS, AccC, the counter, and Ovf; clr_i beats a simultaneous in_valid_i, and no operand is accepted.
REQ-026 SHALL ignore clr_i in RESOLVE and OUT.
REQ-027 SHALL ignore in_valid_i, PS, PC, and Last outside ACC.

Reset
REQ-028 SHALL, while rst_ni=0, asynchronously force state=ACC, AccS=AccC=0, counter=0, carry=0, chunk index=0, Z=0, Ovf=0, out_valid_o=0.
REQ-029 SHALL abandon any RESOLVE/OUT in progress when reset is asserted mid-operation; after release, in_ready_o = !clr_i.

Structure
REQ-030 SHALL take its state enum typedef (csv_acc_state_e) and the speed_e type from lau_pkg.
REQ-031 SHALL instantiate AddMopCsv #(accWidth, 4, speed) as its sole sub-module, for the 4:2 compression.
REQ-032 SHALL keep the chunk adder, FSM, counter, and registers inline.

Verification (widthIn=16, guard=4, chunk=5, N=4)
REQ-033 SHALL test single operand: PS=0x00FF, PC=0x0001, Last=1 -> out_valid_o 4 cycles later, Z=0x00100, Ovf=0.
REQ-034 SHALL test chunk carry chain: two operands PS=0xFFFF, PC=0x0001 (second with Last) -> Z=0x20000.
REQ-035 SHALL test overflow boundary: 16 operands of 0xFFFF/0 -> Z=0xFFFF0, Ovf=0; 17 operands -> Z=0x0FFEF, Ovf=1.
REQ-036 SHALL test backpressure: out_ready_i=0 for 10 cycles -> out_valid_o held, Z stable, in_ready_o=0; after handshake, the next single 0x0003/0x0000 Last operand yields Z=0x00003.
REQ-037 SHALL test clear priority: clr_i=1 with in_valid_i=1 after accumulating 0x0010 -> in_ready_o=0; next Last operand 0x0001/0 yields Z=0x00001.
REQ-038 SHALL test reset during RESOLVE cycle 2 -> all outputs 0, state ACC, in_ready_o=1 after release.
